// File: rtl/mem_resp_router.sv
// mem_resp_router: routes assembled memory response lines back to the requester recorded at issue time.
// Define MEM_RESP_ROUTER_OCC_EN to expose the FIFO occupancy on port occ.
module mem_resp_router #(
    parameter int NUM_DEST   = 2,
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = 4,
    parameter int DEPTH      = 4,
    localparam int DEST_W    = NUM_DEST > 1 ? $clog2(NUM_DEST) : 1,
    localparam int LINE_W    = BEAT_WIDTH * BEATS,
    localparam int OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [DEST_W-1:0]     issue_dest,
    output logic                  issue_ready,
    input  logic                  mem_resp_valid,
    input  logic [BEAT_WIDTH-1:0] mem_rdata,
    output logic [LINE_W-1:0]     line_rdata,
    output logic [NUM_DEST-1:0]   line_resp,
    output logic                  orphan_err
`ifdef MEM_RESP_ROUTER_OCC_EN
    ,
    output logic [OCC_W-1:0]      occ
`endif
);
    localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DELIVER = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] asm_q, asm_d, line_q, line_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [PTR_W-1:0]  wr_q, rd_q;
    logic [DEST_W-1:0] fifo_q [DEPTH];
    logic              err_q, err_d;
    logic              push, pop, take, last, head_ok;
    logic [DEST_W-1:0] head;

    // The popping slot is freed on the DELIVER edge, so a full FIFO may still accept a push then.
    assign pop         = state_q == DELIVER;
    assign issue_ready = occ_q != OCC_W'(DEPTH) || pop;
    assign push        = issue_valid && issue_ready;
    assign head        = fifo_q[rd_q];
    assign head_ok     = int'(head) < NUM_DEST;
    assign take        = mem_resp_valid && (state_q == COLLECT || (state_q == IDLE && occ_q != '0) ||
                                            (pop && occ_q > OCC_W'(1)));
    assign last        = cnt_q == CNT_W'(BEATS - 1);
    assign line_resp   = (pop && head_ok) ? NUM_DEST'(1) << head : '0;
    assign line_rdata  = line_q;
    assign orphan_err  = err_q;
`ifdef MEM_RESP_ROUTER_OCC_EN
    assign occ         = occ_q;
`endif

    always_comb begin
        asm_d = asm_q;
        if (take) asm_d[cnt_q * BEAT_WIDTH +: BEAT_WIDTH] = mem_rdata;
        line_d  = (take && last) ? asm_d : line_q;
        cnt_d   = take ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
        state_d = take ? (last ? DELIVER : COLLECT) : (pop ? IDLE : state_q);
        err_d   = err_q | (mem_resp_valid && !take) | (pop && !head_ok);
        occ_d   = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            line_q  <= '0;
            occ_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            line_q  <= line_d;
            occ_q   <= occ_d;
            wr_q    <= push ? wr_q + 1'b1 : wr_q;
            rd_q    <= pop ? rd_q + 1'b1 : rd_q;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q] <= issue_dest;
    end
endmodule

// File: tb/tb_mem_resp_router.sv
// tb_mem_resp_router: vector table plus scoreboard of expected line deliveries.
module tb_mem_resp_router;
    logic         clk = 1'b0, rst = 1'b1;
    logic         issue_valid = 1'b0, issue_dest = 1'b0, mem_resp_valid = 1'b0;
    logic [63:0]  mem_rdata = '0;
    logic         issue_ready, orphan_err;
    logic [255:0] line_rdata;
    logic [1:0]   line_resp;
`ifdef MEM_RESP_ROUTER_OCC_EN
    logic [2:0]   occ;
`endif

    typedef struct {logic [1:0] resp; logic [255:0] line;} exp_t;
    typedef struct {logic dest; logic [63:0] b0, b1, b2, b3; int gap; logic [1:0] resp;} vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[5];
    int n_vec = 0, n_err = 0, cyc = 0, n_strobe = 0, strobe_cyc = 0, last_gap = 0, last_cyc = 0, s;

    mem_resp_router dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_dest(issue_dest),
        .issue_ready(issue_ready), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .line_rdata(line_rdata), .line_resp(line_resp), .orphan_err(orphan_err)
`ifdef MEM_RESP_ROUTER_OCC_EN
        , .occ(occ)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && line_resp !== 2'b00) begin
            n_strobe++;
            last_gap   = cyc - strobe_cyc;
            strobe_cyc = cyc;
            chk("onehot", 256'($onehot(line_resp)), 256'd1);
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_strobe: got line_resp=%b with nothing outstanding", line_resp);
            end else begin
                mon_e = sb.pop_front();
                chk("line_resp", 256'(line_resp), 256'(mon_e.resp));
                chk("line_rdata", line_rdata, mon_e.line);
            end
        end
    end

    function automatic logic [255:0] mk(input logic [63:0] b);
        return {b + 64'd3, b + 64'd2, b + 64'd1, b};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic d);
        issue_valid = 1'b1;
        issue_dest  = d;
        idle(1);
        issue_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d);
        mem_resp_valid = 1'b1;
        mem_rdata      = d;
        last_cyc       = cyc;
        idle(1);
        mem_resp_valid = 1'b0;
    endtask

    task automatic send_line(input logic [255:0] ln, input int gap);
        for (int k = 0; k < 4; k++) begin
            send_beat(ln[k*64 +: 64]);
            if (k < 3) idle(gap);
        end
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin
            idle(1);
            t++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d lines still pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{1'b1, 64'h11, 64'h22, 64'h33, 64'h44, 0, 2'b10};
        vt[1] = '{1'b0, 64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A, 64'hDEADBEEF00000001, 64'h0123456789ABCDEF, 2, 2'b01};
        vt[2] = '{1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000001, 64'h7FFFFFFFFFFFFFFE, 64'hFFFFFFFF00000000, 1, 2'b10};
        vt[3] = '{1'b0, 64'hCAFEF00DCAFEF00D, 64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 0, 2'b01};
        vt[4] = '{1'b1, 64'h0, 64'h0, 64'h0, 64'h0, 3, 2'b10};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_line_rdata", line_rdata, 256'd0);
        chk("rst_line_resp", 256'(line_resp), 256'd0);
        chk("rst_orphan", 256'(orphan_err), 256'd0);
        chk("rst_ready", 256'(issue_ready), 256'd1);
`ifdef MEM_RESP_ROUTER_OCC_EN
        chk("rst_occ", 256'(occ), 256'd0);
`endif
        rst = 1'b0;
        idle(1);
        // Orphan beat with nothing outstanding
        send_beat(64'hDEAD);
        chk("orphan_set", 256'(orphan_err), 256'd1);
        idle(5);
        chk("orphan_sticky", 256'(orphan_err), 256'd1);
        chk("orphan_line", line_rdata, 256'd0);
        chk("orphan_nostrobe", 256'(n_strobe), 256'd0);
        rst = 1'b1;
        #1;
        chk("orphan_rst_clear", 256'(orphan_err), 256'd0);
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{vt[i].resp, {vt[i].b3, vt[i].b2, vt[i].b1, vt[i].b0}});
            issue(vt[i].dest);
            send_line({vt[i].b3, vt[i].b2, vt[i].b1, vt[i].b0}, vt[i].gap);
            wait_drain(40);
            chk("latency", 256'(strobe_cyc - last_cyc), 256'd1);
            chk("ready_empty", 256'(issue_ready), 256'd1);
            chk("orphan_clear", 256'(orphan_err), 256'd0);
        end
        // Back-to-back lines with no gap
        sb.push_back('{2'b01, mk(64'd1)});
        sb.push_back('{2'b10, mk(64'd5)});
        issue(1'b0);
`ifdef MEM_RESP_ROUTER_OCC_EN
        chk("occ_1", 256'(occ), 256'd1);
`endif
        issue(1'b1);
`ifdef MEM_RESP_ROUTER_OCC_EN
        chk("occ_2", 256'(occ), 256'd2);
`endif
        for (int i = 0; i < 8; i++) begin
            send_beat(64'(i + 1));
`ifdef MEM_RESP_ROUTER_OCC_EN
            if (i == 4) chk("occ_pop", 256'(occ), 256'd1);
`endif
        end
        wait_drain(40);
        chk("b2b_gap", 256'(last_gap), 256'd4);
        chk("b2b_orphan", 256'(orphan_err), 256'd0);
        // Full FIFO, ignored push, push during pop
        for (int j = 0; j < 4; j++) begin
            sb.push_back('{(j % 2) ? 2'b10 : 2'b01, mk(64'h100 + 64'(16 * j))});
            issue(1'(j % 2));
        end
        chk("full_not_ready", 256'(issue_ready), 256'd0);
        issue(1'b1);
        chk("full_ignored", 256'(issue_ready), 256'd0);
        send_line(mk(64'h100), 0);
        chk("ready_in_pop", 256'(issue_ready), 256'd1);
        sb.push_back('{2'b01, mk(64'h200)});
        issue(1'b0);
        chk("still_full", 256'(issue_ready), 256'd0);
`ifdef MEM_RESP_ROUTER_OCC_EN
        chk("occ_full", 256'(occ), 256'd4);
`endif
        for (int j = 1; j < 4; j++) send_line(mk(64'h100 + 64'(16 * j)), 0);
        send_line(mk(64'h200), 0);
        wait_drain(40);
        chk("drained_ready", 256'(issue_ready), 256'd1);
        chk("full_orphan", 256'(orphan_err), 256'd0);
        // Reset in the middle of a gapped burst
        sb.push_back('{2'b01, mk(64'h300)});
        issue(1'b0);
        send_beat(64'h300);
        idle(2);
        send_beat(64'h301);
        idle(2);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_line", line_rdata, 256'd0);
        chk("mid_rst_resp", 256'(line_resp), 256'd0);
        chk("mid_rst_orphan", 256'(orphan_err), 256'd0);
        chk("mid_rst_ready", 256'(issue_ready), 256'd1);
        idle(1);
        rst = 1'b0;
        s = n_strobe;
        idle(10);
        chk("mid_rst_nostrobe", 256'(n_strobe), 256'(s));
        sb.push_back('{2'b10, mk(64'h400)});
        issue(1'b1);
        send_line(mk(64'h400), 2);
        wait_drain(40);
        chk("post_rst_latency", 256'(strobe_cyc - last_cyc), 256'd1);
        chk("post_rst_orphan", 256'(orphan_err), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
